// File: rtl/uart_tx_buf_pkg.sv
// rtl/uart_tx_buf_pkg.sv - shared offsets, state encodings and helpers for uart_tx_buf
//
// Purpose: CPU register offsets, downstream uart register offsets, CTRL/STATUS
// bit positions and the master FSM encoding, shared by the buffer and its bench.
// Ports: none (package).

package uart_tx_buf_pkg;

  // CPU-side register offsets (only addr[7:0] is decoded)
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_TXDATA = 8'h08;

  // CTRL bit positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_RXEN_BIT  = 2;

  // STATUS bit positions
  localparam int STAT_OVF_BIT = 2;

  // Downstream uart register offsets
  localparam logic [31:0] UART_CTRL   = 32'h0000_0000;
  localparam logic [31:0] UART_STATUS = 32'h0000_0004;
  localparam logic [31:0] UART_TXDATA = 32'h0000_000C;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_POLL  = 3'd2,
    S_WRITE = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // STATUS layout: bit0 full, bit1 empty, bit2 overflow, bits[12:4] count
  function automatic logic [31:0] status_word(input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [8:0] count);
    status_word = {19'b0, count, 1'b0, ovf, empty, full};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous byte FIFO with flush and occupancy count
//
// Purpose: power-of-two deep FIFO; pointers wrap naturally modulo DEPTH.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   push, wdata     write request and data; accepted when not full, or when a
//                   pop happens in the same cycle
//   pop, rdata      read request; rdata is the head entry (combinational)
//   flush           clears pointers and count, overriding push/pop
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH

module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A pop frees the slot this cycle, so a push at full is still accepted;
  // at full wr_ptr == rd_ptr and the head is read before the overwrite.
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && !flush && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - CPU-facing TX byte buffer that feeds a uart register port
//
// Purpose: buffers CPU bytes in a FIFO and drains them into a downstream uart
// by polling its STATUS busy bit and writing its TXDATA register.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   we_i              CPU register write strobe
//   addr_i, data_i    CPU address (addr_i[7:0] decoded) and write data
//   data_o            CPU read data, combinational from addr_i
//   u_we_o            write strobe to the uart register port
//   u_addr_o          uart register address
//   u_data_o          uart write data
//   u_data_i          uart read data (its combinational data_o)

module uart_tx_buf
  import uart_tx_buf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        u_we_o,
  output logic [31:0] u_addr_o,
  output logic [31:0] u_data_o,
  input  logic [31:0] u_data_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]  addr_lo;
  logic        ctrl_wr;
  logic        status_wr;
  logic        push_req;

  logic        ctrl_en;
  logic        ctrl_rx;
  logic        flush_q;
  logic        ovf;
  logic        en_prev;
  state_t      state;

  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic [8:0]  count9;
  logic        ovf_set;
  logic        ovf_clr;

  logic        unused_bits;

  assign addr_lo   = addr_i[7:0];
  assign ctrl_wr   = we_i && (addr_lo == REG_CTRL);
  assign status_wr = we_i && (addr_lo == REG_STATUS);
  assign push_req  = we_i && (addr_lo == REG_TXDATA);

  // Bytes pushed while the flush pulse is high vanish with the flush.
  assign fifo_push = push_req && !flush_q;
  assign fifo_pop  = (state == S_WRITE);

  // A push at full is only an overflow when no pop makes room this cycle.
  assign ovf_set = push_req && !flush_q && fifo_full && !fifo_pop;
  assign ovf_clr = status_wr && data_i[STAT_OVF_BIT];

  assign count9 = 9'(fifo_count);

  assign unused_bits = ^{addr_i[31:8], data_i[31:8], u_data_i[31:1]};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush_q),
    .wdata (data_i[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // CTRL / STATUS registers; flush is a one-cycle pulse following the write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_en <= 1'b0;
      ctrl_rx <= 1'b0;
      flush_q <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      flush_q <= ctrl_wr && data_i[CTRL_FLUSH_BIT];
      if (ctrl_wr) begin
        ctrl_en <= data_i[CTRL_EN_BIT];
        ctrl_rx <= data_i[CTRL_RXEN_BIT];
      end
      // A fresh overflow wins over a simultaneous clear so no drop is missed.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Read mux is forced to zero while reset is held.
  always_comb begin
    data_o = '0;
    if (rst) begin
      case (addr_lo)
        REG_CTRL:   data_o = {29'b0, ctrl_rx, flush_q, ctrl_en};
        REG_STATUS: data_o = status_word(fifo_full, fifo_empty, ovf, count9);
        default:    data_o = '0;
      endcase
    end
  end

  // Master FSM. The uart outputs are registered alongside the state, so each
  // transition loads the outputs that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      en_prev  <= 1'b0;
      u_we_o   <= 1'b0;
      u_addr_o <= UART_STATUS;
      u_data_o <= '0;
    end else begin
      en_prev  <= ctrl_en;
      u_we_o   <= 1'b0;
      u_addr_o <= UART_STATUS;
      u_data_o <= '0;
      if (state != S_IDLE && (!ctrl_en || flush_q)) begin
        // Abort; a byte already on the uart port is not recalled.
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (ctrl_en && !en_prev) begin
              state    <= S_INIT;
              u_we_o   <= 1'b1;
              u_addr_o <= UART_CTRL;
              u_data_o <= {29'b0, 1'b0, ctrl_rx, 1'b1};
            end else if (ctrl_en && !fifo_empty && !flush_q) begin
              state <= S_POLL;
            end
          end
          S_INIT: begin
            state <= S_IDLE;
          end
          S_POLL: begin
            // u_data_i is the uart STATUS here; bit0 is its busy flag.
            if (!u_data_i[0]) begin
              state    <= S_WRITE;
              u_we_o   <= 1'b1;
              u_addr_o <= UART_TXDATA;
              u_data_o <= {24'b0, fifo_rdata};
            end
          end
          S_WRITE: begin
            state <= S_GAP;
          end
          S_GAP: begin
            // One cycle for the uart to raise busy before polling resumes.
            state <= (ctrl_en && !fifo_empty) ? S_POLL : S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - self-checking bench for uart_tx_buf with a busy-flag uart model

module tb_uart_tx_buf;
  import uart_tx_buf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        u_we_o;
  logic [31:0] u_addr_o;
  logic [31:0] u_data_o;
  logic [31:0] u_data_i;

  always #5 clk = ~clk;

  uart_tx_buf #(.DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .u_we_o   (u_we_o),
    .u_addr_o (u_addr_o),
    .u_data_o (u_data_o),
    .u_data_i (u_data_i)
  );

  int vectors = 0;
  int fails   = 0;

  logic [7:0]  sb[$];
  logic [31:0] init_q[$];

  int busy_cycles  = 10;
  int busy_cnt     = 0;
  bit mon_en       = 1'b0;
  bit prev_poll_ok = 1'b0;
  int wr_count     = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // uart model: STATUS bit0 busy for busy_cycles after each TXDATA write
  assign u_data_i = (u_addr_o == 32'h4) ? {31'b0, (busy_cnt != 0)} : 32'h0;

  always @(posedge clk) begin
    if (u_we_o === 1'b1 && u_addr_o == 32'hC) busy_cnt <= busy_cycles;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (u_we_o && u_addr_o == 32'hC) begin
        wr_count++;
        chk("poll_idle_before_write", prev_poll_ok, 1);
        chk("init_before_data", init_q.size(), 0);
        chk("byte_expected", sb.size() != 0, 1);
        if (sb.size() != 0) chk("byte_data", u_data_o, {24'b0, sb.pop_front()});
      end else if (u_we_o && u_addr_o == 32'h0) begin
        chk("init_expected", init_q.size() != 0, 1);
        if (init_q.size() != 0) chk("init_data", u_data_o, init_q.pop_front());
      end else if (u_we_o) begin
        chk("we_addr", u_addr_o, 32'hC);
      end else begin
        chk("idle_outputs", {u_addr_o[3:0], u_data_o[27:0]}, {4'h4, 28'h0});
      end
      prev_poll_ok = (!u_we_o && u_addr_o == 32'h4 && u_data_i[0] == 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; data_i = d;
    tick();
    we_i = 1'b0; addr_i = '0; data_i = '0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr_i = a;
    #1;
    chk(name, data_o, exp);
    addr_i = '0;
  endtask

  task automatic wait_write(input int budget);
    int i = 0;
    while (!(u_we_o && u_addr_o == 32'hC) && i < budget) begin
      tick();
      i++;
    end
    chk("wait_write_timeout", i < budget, 1);
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((sb.size() != 0 || dut.state != S_IDLE) && i < budget) begin
      tick();
      i++;
    end
    chk("drain_timeout", i < budget, 1);
  endtask

  function automatic void add(input bit we, input logic [31:0] a, input logic [31:0] d,
                              input bit c, input logic [31:0] e, input string n);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.chk = c; v.exp = e; v.name = n;
    tbl.push_back(v);
  endfunction

  initial begin
    int c;
    int wc;

    rst = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    tick();
    addr_i = 32'h4;
    #1;
    chk("rst_u_we", u_we_o, 0);
    chk("rst_u_addr", u_addr_o, 32'h4);
    chk("rst_u_data", u_data_o, 0);
    chk("rst_data_o", data_o, 0);
    addr_i = '0;
    rst = 1'b1;
    tick();

    // Register-level vectors while disabled (no draining)
    add(0, 32'h00, 0, 1, 32'h0,   "rd_ctrl_reset");
    add(0, 32'h04, 0, 1, 32'h2,   "rd_status_reset");
    add(0, 32'h08, 0, 1, 32'h0,   "rd_txdata_zero");
    add(0, 32'h3C, 0, 1, 32'h0,   "rd_unmapped_zero");
    add(1, 32'h00, 32'h4, 0, 0,   "");
    add(0, 32'h00, 0, 1, 32'h4,   "rd_ctrl_rx");
    add(1, 32'h08, 32'h1AA, 0, 0, "");
    add(0, 32'h04, 0, 1, 32'h10,  "status_count1");
    add(1, 32'h08, 32'h55, 0, 0,  "");
    add(0, 32'h04, 0, 1, 32'h20,  "status_count2");
    add(1, 32'h00, 32'h6, 0, 0,   "");
    add(1, 32'h08, 32'h77, 0, 0,  "");
    add(0, 32'h04, 0, 1, 32'h2,   "flush_empty_no_ovf");
    add(0, 32'h00, 0, 1, 32'h4,   "flush_self_clear");
    add(1, 32'h00, 32'h0, 0, 0,   "");
    for (int i = 0; i < 16; i++) add(1, 32'h08, 32'h80 + i, 0, 0, "");
    add(0, 32'h04, 0, 1, 32'h101, "status_full16");
    add(1, 32'h08, 32'hEE, 0, 0,  "");
    add(0, 32'h04, 0, 1, 32'h105, "status_overflow");
    add(1, 32'h04, 32'h3, 0, 0,   "");
    add(0, 32'h04, 0, 1, 32'h105, "w1c_other_bits");
    add(1, 32'h04, 32'h4, 0, 0,   "");
    add(0, 32'h04, 0, 1, 32'h101, "w1c_overflow");

    foreach (tbl[i]) begin
      we_i = tbl[i].we; addr_i = tbl[i].addr; data_i = tbl[i].data;
      #1;
      if (tbl[i].chk) chk(tbl[i].name, data_o, tbl[i].exp);
      tick();
    end
    we_i = 1'b0; addr_i = '0; data_i = '0;

    // Push at full in the same cycle as the S_WRITE pop
    busy_cycles = 3;
    for (int i = 0; i < 16; i++) sb.push_back(8'h80 + 8'(i));
    init_q.push_back(32'h1);
    cpu_write(32'h0, 32'h1);
    wait_write(20);
    sb.push_back(8'h90);
    cpu_write(32'h8, 32'h90);
    rd_chk("push_pop_at_full", 32'h4, 32'h101);
    wait_drain(1000);
    rd_chk("drained_no_ovf", 32'h4, 32'h2);

    // Re-enable: init write, then two bytes gated on uart busy
    busy_cycles = 10;
    cpu_write(32'h0, 32'h0);
    init_q.push_back(32'h1);
    cpu_write(32'h0, 32'h1);
    sb.push_back(8'h41);
    cpu_write(32'h8, 32'h41);
    sb.push_back(8'h42);
    cpu_write(32'h8, 32'h42);
    wait_drain(1000);
    chk("init_consumed", init_q.size(), 0);

    // Minimum latency from push into empty FIFO to TXDATA write
    repeat (12) tick();
    sb.push_back(8'h5A);
    cpu_write(32'h8, 32'h5A);
    c = 1;
    while (!(u_we_o && u_addr_o == 32'hC) && c < 20) begin
      tick();
      c++;
    end
    chk("latency", c, 3);
    wait_drain(1000);

    // Flush while polling a busy uart
    repeat (12) tick();
    sb.push_back(8'h61);
    for (int i = 0; i < 5; i++) cpu_write(32'h8, 32'h61 + i);
    c = 0;
    while (dut.state != S_POLL && c < 10) begin
      tick();
      c++;
    end
    chk("reach_poll", dut.state, S_POLL);
    cpu_write(32'h0, 32'h3);
    tick();
    chk("flush_fsm_idle", dut.state, S_IDLE);
    rd_chk("flush_status", 32'h4, 32'h2);
    wc = wr_count;
    repeat (40) tick();
    chk("no_write_after_flush", wr_count, wc);

    // Reset asserted during S_WRITE
    repeat (12) tick();
    sb.push_back(8'h71);
    cpu_write(32'h8, 32'h71);
    cpu_write(32'h8, 32'h72);
    cpu_write(32'h8, 32'h73);
    wait_write(10);
    rst = 1'b0;
    tick();
    chk("rstw_u_we", u_we_o, 0);
    chk("rstw_u_addr", u_addr_o, 32'h4);
    rd_chk("rstw_data_o", 32'h4, 32'h0);
    wc = wr_count;
    tick();
    rst = 1'b1;
    tick();
    rd_chk("rstw_status", 32'h4, 32'h2);
    rd_chk("rstw_ctrl", 32'h0, 32'h0);
    repeat (30) tick();
    chk("no_write_after_rst", wr_count, wc);

    // 20 bytes streamed across the pointer wrap
    busy_cycles = 2;
    init_q.push_back(32'h1);
    cpu_write(32'h0, 32'h1);
    for (int i = 0; i < 20; i++) begin
      sb.push_back(8'hA0 + 8'(i));
      cpu_write(32'h8, 32'hA0 + i);
      tick();
    end
    wait_drain(2000);
    rd_chk("stream_status", 32'h4, 32'h2);
    chk("sb_empty_end", sb.size(), 0);
    chk("init_empty_end", init_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
